// File: rtl/sevenseg_pkg.sv
// Shared constants and the hex-to-segment lookup for the 7-segment scanner.
// Segment vectors are {g,f,e,d,c,b,a}, active-low (common-anode display).
package sevenseg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        hex_to_seg = SEG_BLANK;
        case (hex)
            4'h0: hex_to_seg = SEG_0;
            4'h1: hex_to_seg = SEG_1;
            4'h2: hex_to_seg = SEG_2;
            4'h3: hex_to_seg = SEG_3;
            4'h4: hex_to_seg = SEG_4;
            4'h5: hex_to_seg = SEG_5;
            4'h6: hex_to_seg = SEG_6;
            4'h7: hex_to_seg = SEG_7;
            4'h8: hex_to_seg = SEG_8;
            4'h9: hex_to_seg = SEG_9;
            4'hA: hex_to_seg = SEG_A;
            4'hB: hex_to_seg = SEG_B;
            4'hC: hex_to_seg = SEG_C;
            4'hD: hex_to_seg = SEG_D;
            4'hE: hex_to_seg = SEG_E;
            4'hF: hex_to_seg = SEG_F;
        endcase
    endfunction

endpackage

// File: rtl/sevenseg_scan_if.sv
// Scanner bus: tick/value/blank in, anode/segment/frame outputs.
// The slave modport is the scanner itself; master is whoever drives it.
interface sevenseg_scan_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int VAL_W = 4 * NUM_DIGITS;

    logic                  tick_in;
    logic [VAL_W-1:0]      value_in;
    logic                  blank_i;
    logic [NUM_DIGITS-1:0] an_n;
    logic [6:0]            seg_n;
    logic                  frame_done;

    modport master (
        output tick_in, value_in, blank_i,
        input  an_n, seg_n, frame_done
    );

    modport slave (
        input  tick_in, value_in, blank_i,
        output an_n, seg_n, frame_done
    );

endinterface

// File: rtl/sevenseg_decode.sv
// Combinational hex digit to active-low segment decoder.
module sevenseg_decode
    import sevenseg_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(digit);

endmodule

// File: rtl/sevenseg_scan.sv
// Time-multiplexed common-anode 7-segment scanner driven by a slow tick on clk.
// Optional leading-zero blanking when SEVSEG_LZ_BLANK_EN is defined.
module sevenseg_scan
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    sevenseg_scan_if.slave bus
);

    localparam int VAL_W = 4 * NUM_DIGITS;
    localparam int IDX_W = idx_width(NUM_DIGITS);

    logic                  tick_q, tick_d, tick_edge;
    logic [IDX_W-1:0]      idx;
    logic                  wrap;
    logic [VAL_W-1:0]      shadow;
    logic [3:0]            digit;
    logic [6:0]            seg_dec;
    logic                  dark;
    logic [NUM_DIGITS-1:0] an_q;
    logic [6:0]            seg_q;
    logic                  frame_q;

    // tick_in is a slow divider output, treated as data: rising-edge detect only.
    // Reset to 1 so a tick held high through reset is not seen as an edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_q <= 1'b1;
            tick_d <= 1'b1;
        end else begin
            tick_q <= bus.tick_in;
            tick_d <= tick_q;
        end
    end

    assign tick_edge = tick_q & ~tick_d;
    assign wrap      = (idx == IDX_W'(NUM_DIGITS - 1));

    // Shadow only reloads at wrap so each frame shows one coherent value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx     <= '0;
            shadow  <= '0;
            frame_q <= 1'b0;
        end else begin
            frame_q <= tick_edge & wrap;
            if (tick_edge) begin
                idx <= wrap ? '0 : idx + 1'b1;
                if (wrap) shadow <= bus.value_in;
            end
        end
    end

    always_comb begin
        digit = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (idx == IDX_W'(i)) digit = shadow[i*4 +: 4];
    end

    sevenseg_decode u_decode (
        .digit (digit),
        .seg   (seg_dec)
    );

`ifdef SEVSEG_LZ_BLANK_EN
    // Highest non-zero digit; digit 0 is always lit, so msd defaults to 0.
    logic [IDX_W-1:0] msd;
    always_comb begin
        msd = '0;
        for (int i = 1; i < NUM_DIGITS; i++)
            if (shadow[i*4 +: 4] != 4'h0) msd = IDX_W'(i);
    end
    assign dark = (idx > msd);
`else
    assign dark = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an_q  <= '1;
            seg_q <= SEG_BLANK;
        end else begin
            an_q  <= (bus.blank_i || dark) ? '1 : ~(NUM_DIGITS'(1) << idx);
            seg_q <= dark ? SEG_BLANK : seg_dec;
        end
    end

    assign bus.an_n       = an_q;
    assign bus.seg_n      = seg_q;
    assign bus.frame_done = frame_q;

endmodule
